// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the decode-stage immediate generator.
// Upstream request side and downstream result side share one bundle.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      instr;
  logic [2:0]       immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  immext;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;

  modport master (
    output in_valid, instr, immsrc, in_tag, out_ready,
    input  in_ready, out_valid, immext, out_tag, illegal
  );

  modport slave (
    input  in_valid, instr, immsrc, in_tag, out_ready,
    output in_ready, out_valid, immext, out_tag, illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator, XLEN-parametrised,
// registered behind a 2-entry skid buffer (M drives outputs, K is skid).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  m_imm_q, m_imm_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d;
  logic             m_ill_q, m_ill_d;
  logic [XLEN-1:0]  k_imm_q, k_imm_d;
  logic [TAG_W-1:0] k_tag_q, k_tag_d;
  logic             k_ill_q, k_ill_d;

  logic [31:7]     ins;
  logic [63:0]     wide;
  logic [XLEN-1:0] ext_imm;
  logic            ext_ill;
  logic            acc;
  logic            drn;

  assign ins = bus.instr;

  // Build every format at 64 bits, then keep the low XLEN
  always_comb begin
    wide    = '0;
    ext_ill = 1'b0;
    unique case (bus.immsrc)
      3'b000: wide = {{52{ins[31]}}, ins[31:20]};
      3'b001: wide = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010: wide = {{52{ins[31]}}, ins[7],
                      ins[30:25], ins[11:8], 1'b0};
      3'b011: wide = {{44{ins[31]}}, ins[19:12], ins[20],
                      ins[30:21], 1'b0};
      3'b100: wide = {{32{ins[31]}}, ins[31:12], 12'b0};
      3'b101: wide = (XLEN == 64) ? {58'b0, ins[25:20]}
                                  : {59'b0, ins[24:20]};
      3'b110: wide = {59'b0, ins[19:15]};
      default: ext_ill = 1'b1;
    endcase
    ext_imm = wide[XLEN-1:0];
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.immext    = m_imm_q;
  assign bus.out_tag   = m_tag_q;
  assign bus.illegal   = m_ill_q;

  assign acc = bus.in_valid & bus.in_ready;
  assign drn = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    m_imm_d = m_imm_q;
    m_tag_d = m_tag_q;
    m_ill_d = m_ill_q;
    k_imm_d = k_imm_q;
    k_tag_d = k_tag_q;
    k_ill_d = k_ill_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          m_imm_d = ext_imm;
          m_tag_d = bus.in_tag;
          m_ill_d = ext_ill;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && drn) begin
          m_imm_d = ext_imm;
          m_tag_d = bus.in_tag;
          m_ill_d = ext_ill;
        end else if (acc) begin
          k_imm_d = ext_imm;
          k_tag_d = bus.in_tag;
          k_ill_d = ext_ill;
          state_d = FULL;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          m_imm_d = k_imm_q;
          m_tag_d = k_tag_q;
          m_ill_d = k_ill_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      m_imm_q <= '0;
      m_tag_q <= '0;
      m_ill_q <= 1'b0;
      k_imm_q <= '0;
      k_tag_q <= '0;
      k_ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_imm_q <= m_imm_d;
      m_tag_q <= m_tag_d;
      m_ill_q <= m_ill_d;
      k_imm_q <= k_imm_d;
      k_tag_q <= k_tag_d;
      k_ill_q <= k_ill_d;
    end
  end

endmodule
